// File: rtl/roc_pkg.sv
// Shared definitions for the rank-order-coding AER link.
// Used by both encoder and decoder sides.
package roc_pkg;

    localparam logic [9:0] AER_RST_ADDR = 10'h1FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_COLLECT,
        ST_DONE
    } roc_state_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_RST,
        EV_PIX
    } roc_evt_e;

    function automatic roc_evt_e evt_class(
        input logic [9:0]  addr,
        input int unsigned n_pix
    );
        roc_evt_e ev;
        ev = EV_NONE;
        if (addr == AER_RST_ADDR)
            ev = EV_RST;
        else if (addr[9:8] == 2'b00 && 32'(addr[7:0]) < n_pix)
            ev = EV_PIX;
        return ev;
    endfunction

endpackage

// File: rtl/roc_decoder_if.sv
// 10-bit AER link with 4-phase REQ/ACK handshake.
// The sender is the master, the receiver the slave.
interface roc_decoder_if;

    logic [9:0] AERIN_ADDR;
    logic       AERIN_REQ;
    logic       AERIN_ACK;

    modport master (
        output AERIN_ADDR,
        output AERIN_REQ,
        input  AERIN_ACK
    );

    modport slave (
        input  AERIN_ADDR,
        input  AERIN_REQ,
        output AERIN_ACK
    );

endinterface

// File: rtl/aer_rx_handshake.sv
// AER receive handshake: REQ synchronizer, ACK generation,
// address latch and a single event strobe per REQ phase.
module aer_rx_handshake (
    input  logic          CLK,
    input  logic          RST,
    roc_decoder_if.slave  aer,
    output logic          evt_stb,
    output logic [9:0]    evt_addr
);

    logic [1:0] req_sync;
    logic       ack;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_sync <= 2'b00;
            ack      <= 1'b0;
            evt_addr <= '0;
            evt_stb  <= 1'b0;
        end else begin
            req_sync <= {req_sync[0], aer.AERIN_REQ};
            evt_stb  <= 1'b0;
            // ACK itself gates the strobe, so one REQ phase yields one event
            if (req_sync[1] && !ack) begin
                ack      <= 1'b1;
                evt_addr <= aer.AERIN_ADDR;
                evt_stb  <= 1'b1;
            end else if (!req_sync[1] && ack) begin
                ack <= 1'b0;
            end
        end
    end

    assign aer.AERIN_ACK = ack;

endmodule

// File: rtl/roc_decoder.sv
// Rank-order-coding decoder: waits for the link reset sequence,
// then rebuilds an image where earlier rank means brighter pixel.
module roc_decoder
    import roc_pkg::*;
#(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_MAX_VALUE = 255,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
    parameter int RANK_SHIFT      = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    roc_decoder_if.slave           aer,
    input  logic                   FLUSH,
    output logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE_OUT,
    output logic [IMAGE_SIZE_BITS:0] RANK,
    output logic                   IMAGE_VALID,
    output logic                   DECODER_RDY
);

    localparam int unsigned PMAX = PIXEL_MAX_VALUE;
    localparam logic [IMAGE_SIZE_BITS:0] LAST_RANK =
        (IMAGE_SIZE_BITS+1)'(IMAGE_SIZE - 1);

    logic                       evt_stb;
    logic [9:0]                 evt_addr;
    roc_evt_e                   ev;
    roc_state_e                 state;
    logic [IMAGE_SIZE-1:0]      written;
    logic [IMAGE_SIZE_BITS-1:0] idx;
    logic [IMAGE_SIZE_BITS:0]   rank_sh;
    logic [PIXEL_BITS-1:0]      pix_val;
    logic                       is_rst;
    logic                       new_pix;
    logic                       last_pix;

    aer_rx_handshake u_hs (
        .CLK      (CLK),
        .RST      (RST),
        .aer      (aer),
        .evt_stb  (evt_stb),
        .evt_addr (evt_addr)
    );

    assign ev      = evt_class(evt_addr, IMAGE_SIZE);
    assign idx     = evt_addr[IMAGE_SIZE_BITS-1:0];
    assign is_rst  = evt_stb && ev == EV_RST;
    assign new_pix = evt_stb && ev == EV_PIX && !written[idx];
    assign last_pix = new_pix && RANK == LAST_RANK;
    assign rank_sh = RANK >> RANK_SHIFT;

    // saturate before subtracting so late ranks clamp at 0
    always_comb begin
        int unsigned r;
        r = 32'(rank_sh);
        if (r > PMAX)
            r = PMAX;
        pix_val = PIXEL_BITS'(PMAX - r);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            IMAGE_OUT <= '0;
            written   <= '0;
            RANK      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (is_rst)
                        state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (is_rst) begin
                        state     <= ST_COLLECT;
                        IMAGE_OUT <= '0;
                        written   <= '0;
                        RANK      <= '0;
                    end else if (evt_stb && ev == EV_PIX) begin
                        state <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (is_rst) begin
                        state <= ST_ARMED;
                    end else begin
                        if (new_pix) begin
                            IMAGE_OUT[idx] <= pix_val;
                            written[idx]   <= 1'b1;
                            RANK           <= RANK + 1'b1;
                        end
                        if (last_pix || FLUSH)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (is_rst)
                        state <= ST_ARMED;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign IMAGE_VALID = state == ST_DONE;
    assign DECODER_RDY = state == ST_IDLE;

endmodule
